// File: rtl/axi_stream_strip_header.sv
// rtl/axi_stream_strip_header.sv - strips a leading header from an AXI-Stream packet
// and re-aligns the remaining payload to the MSB byte lane.
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_strip,
   input  logic [BYTE_CNT_WD:0]      byte_strip_cnt,
   output logic                      ready_strip,
   input  logic                      valid_in,
   input  logic [DATA_WD-1:0]        data_in,
   input  logic [DATA_BYTE_WD-1:0]   keep_in,
   input  logic                      last_in,
   output logic                      ready_in,
   output logic                      valid_hdr,
   output logic [DATA_WD-1:0]        data_hdr,
   output logic [DATA_BYTE_WD-1:0]   keep_hdr,
   input  logic                      ready_hdr,
   output logic                      valid_out,
   output logic [DATA_WD-1:0]        data_out,
   output logic [DATA_BYTE_WD-1:0]   keep_out,
   output logic                      last_out,
   input  logic                      ready_out,
   output logic                      err_short
);

   localparam int CW = BYTE_CNT_WD + 1;
   localparam int NB = DATA_BYTE_WD;

   typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     c_q, c_d;
   logic [CW-1:0]     r_q, r_d;
   logic [CW-1:0]     flush_cnt_q, flush_cnt_d;
   logic [DATA_WD-1:0] resid_q, resid_d;
   logic              valid_hdr_q, valid_hdr_d;
   logic [DATA_WD-1:0] data_hdr_q, data_hdr_d;
   logic [NB-1:0]     keep_hdr_q, keep_hdr_d;
   logic              valid_out_q, valid_out_d;
   logic [DATA_WD-1:0] data_out_q, data_out_d;
   logic [NB-1:0]     keep_out_q, keep_out_d;
   logic              last_out_q, last_out_d;
   logic              err_short_q, err_short_d;

   logic              hdr_free, out_free, acc;
   logic [CW-1:0]     k_in, c_clamp;
   logic [CW:0]       rk;
   logic [DATA_WD-1:0] din_m, resid_new, body_data;

   function automatic logic [NB-1:0] top_ones(input logic [CW:0] n);
      top_ones = ~({NB{1'b1}} >> n);
   endfunction

   function automatic logic [NB-1:0] low_ones(input logic [CW-1:0] n);
      low_ones = ~({NB{1'b1}} << n);
   endfunction

   // Bytes outside keep_in are zeroed so they never leak into header, payload or residual.
   always_comb begin
      k_in  = '0;
      din_m = '0;
      for (int i = 0; i < NB; i++) begin
         k_in = k_in + {{(CW-1){1'b0}}, keep_in[i]};
         din_m[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
      end
   end

   assign c_clamp   = (byte_strip_cnt > CW'(NB)) ? CW'(NB) : byte_strip_cnt;
   assign resid_new = din_m << {c_q, 3'b000};
   assign body_data = resid_q | (din_m >> {r_q, 3'b000});
   assign rk        = {1'b0, r_q} + {1'b0, k_in};

   assign hdr_free = !valid_hdr_q || ready_hdr;
   assign out_free = !valid_out_q || ready_out;

   always_comb begin
      ready_in = 1'b0;
      case (state_q)
         S_HEAD:  ready_in = hdr_free && out_free;
         S_BODY:  ready_in = out_free;
         default: ready_in = 1'b0;
      endcase
      ready_in = ready_in && rst_n;
   end

   assign ready_strip = rst_n && (state_q == S_IDLE);
   assign acc         = valid_in && ready_in;

   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      r_d         = r_q;
      flush_cnt_d = flush_cnt_q;
      resid_d     = resid_q;
      valid_hdr_d = valid_hdr_q && !ready_hdr;
      data_hdr_d  = data_hdr_q;
      keep_hdr_d  = keep_hdr_q;
      valid_out_d = valid_out_q && !ready_out;
      data_out_d  = data_out_q;
      keep_out_d  = keep_out_q;
      last_out_d  = last_out_q;
      err_short_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_strip) begin
               c_d     = c_clamp;
               r_d     = CW'(NB) - c_clamp;
               state_d = S_HEAD;
            end
         end
         S_HEAD: begin
            if (acc) begin
               resid_d = resid_new;
               if (c_q != '0) begin
                  valid_hdr_d = 1'b1;
                  data_hdr_d  = din_m >> {r_q, 3'b000};
                  keep_hdr_d  = low_ones(c_q);
               end
               if (!last_in) begin
                  state_d = S_BODY;
               end else begin
                  state_d = S_IDLE;
                  if (k_in > c_q) begin
                     valid_out_d = 1'b1;
                     data_out_d  = resid_new;
                     keep_out_d  = keep_in << c_q;
                     last_out_d  = 1'b1;
                  end else if (k_in < c_q) begin
                     // Short packet: header holds only the bytes that arrived.
                     data_hdr_d  = din_m >> {(CW'(NB) - k_in), 3'b000};
                     keep_hdr_d  = low_ones(k_in);
                     err_short_d = 1'b1;
                  end
               end
            end
         end
         S_BODY: begin
            if (acc) begin
               valid_out_d = 1'b1;
               data_out_d  = body_data;
               resid_d     = resid_new;
               keep_out_d  = {NB{1'b1}};
               last_out_d  = 1'b0;
               if (last_in) begin
                  if (rk <= (CW+1)'(NB)) begin
                     keep_out_d = top_ones(rk);
                     last_out_d = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     flush_cnt_d = CW'(rk - (CW+1)'(NB));
                     state_d     = S_FLUSH;
                  end
               end
            end
         end
         S_FLUSH: begin
            if (out_free) begin
               valid_out_d = 1'b1;
               data_out_d  = resid_q;
               keep_out_d  = top_ones({1'b0, flush_cnt_q});
               last_out_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         c_q         <= '0;
         r_q         <= '0;
         flush_cnt_q <= '0;
         resid_q     <= '0;
         valid_hdr_q <= 1'b0;
         data_hdr_q  <= '0;
         keep_hdr_q  <= '0;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
         keep_out_q  <= '0;
         last_out_q  <= 1'b0;
         err_short_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         r_q         <= r_d;
         flush_cnt_q <= flush_cnt_d;
         resid_q     <= resid_d;
         valid_hdr_q <= valid_hdr_d;
         data_hdr_q  <= data_hdr_d;
         keep_hdr_q  <= keep_hdr_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
         keep_out_q  <= keep_out_d;
         last_out_q  <= last_out_d;
         err_short_q <= err_short_d;
      end
   end

   assign valid_hdr = valid_hdr_q;
   assign data_hdr  = data_hdr_q;
   assign keep_hdr  = keep_hdr_q;
   assign valid_out = valid_out_q;
   assign data_out  = data_out_q;
   assign keep_out  = keep_out_q;
   assign last_out  = last_out_q;
   assign err_short = err_short_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb/tb_axi_stream_strip_header.sv - randomized scoreboard bench for axi_stream_strip_header.
module tb_axi_stream_strip_header;
   localparam int DW = 32;
   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_strip = 1'b0;
   logic [2:0]    byte_strip_cnt = '0;
   logic          ready_strip;
   logic          valid_in = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [NB-1:0] keep_in = '0;
   logic          last_in = 1'b0;
   logic          ready_in;
   logic          valid_hdr;
   logic [DW-1:0] data_hdr;
   logic [NB-1:0] keep_hdr;
   logic          ready_hdr = 1'b0;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic [NB-1:0] keep_out;
   logic          last_out;
   logic          ready_out = 1'b0;
   logic          err_short;

   axi_stream_strip_header #(.DATA_WD(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
      .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
      .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .ready_out(ready_out), .err_short(err_short)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: expected header and payload beats, in order.
   logic [DW-1:0] eh_d[$];
   logic [NB-1:0] eh_k[$];
   logic [DW-1:0] eo_d[$];
   logic [NB-1:0] eo_k[$];
   logic          eo_l[$];
   logic [7:0]    pkt[$];
   int            exp_err = 0;
   int            obs_err = 0;
   bit            discard = 0;
   bit            hold_hdr = 0;

   // Reference: header = first c bytes, payload = the rest cut into NB-byte beats.
   task automatic model_pkt(input int c);
      int L, h;
      logic [DW-1:0] d;
      logic [NB-1:0] k;
      L = pkt.size();
      if (c > 0) begin
         h = (c < L) ? c : L;
         d = '0;
         for (int i = 0; i < h; i++) d = {d[DW-9:0], pkt[i]};
         k = '0;
         for (int i = 0; i < h; i++) k = {k[NB-2:0], 1'b1};
         eh_d.push_back(d);
         eh_k.push_back(k);
         if (L < c) exp_err++;
      end
      for (int pos = c; pos < L; pos += NB) begin
         d = '0;
         k = '0;
         for (int j = 0; j < NB; j++) begin
            d = {d[DW-9:0], (pos + j < L) ? pkt[pos + j] : 8'h00};
            k = {k[NB-2:0], (pos + j < L)};
         end
         eo_d.push_back(d);
         eo_k.push_back(k);
         eo_l.push_back(pos + NB >= L);
      end
   endtask

   task automatic send_strip(input logic [2:0] cnt);
      int n;
      valid_strip    = 1'b1;
      byte_strip_cnt = cnt;
      n = 0;
      @(negedge clk);
      while (!ready_strip && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!ready_strip) check_eq("strip_timeout", ready_strip, 1);
      @(posedge clk);
      #1 valid_strip = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
      int n;
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      n = 0;
      @(negedge clk);
      while (!ready_in && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!ready_in) check_eq("in_timeout", ready_in, 1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      data_in  = $urandom;
   endtask

   task automatic send_beats();
      int L, B, idx;
      logic [DW-1:0] d;
      logic [NB-1:0] k;
      L = pkt.size();
      B = (L + NB - 1) / NB;
      for (int b = 0; b < B; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < NB; j++) begin
            idx = b * NB + j;
            d = {d[DW-9:0], (idx < L) ? pkt[idx] : 8'($urandom)};
            k = {k[NB-2:0], (idx < L)};
         end
         send_beat(d, k, b == B - 1);
      end
   endtask

   task automatic send_pkt(input logic [2:0] cnt);
      model_pkt((cnt > 3'd4) ? 4 : int'(cnt));
      send_strip(cnt);
      send_beats();
   endtask

   task automatic set_pkt(input logic [63:0] bytes, input int n);
      logic [63:0] v;
      v = bytes;
      pkt.delete();
      for (int i = n - 1; i >= 0; i--) pkt.push_back(v[8*i +: 8]);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((eh_d.size() != 0 || eo_d.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      ready_out = ($urandom_range(0, 3) != 0);
      ready_hdr = hold_hdr ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Output monitor: handshakes against the scoreboard, stability while stalled.
   logic [DW-1:0] ph_d, po_d;
   logic [NB-1:0] ph_k, po_k;
   logic          po_l;
   bit            ph_stall = 0, po_stall = 0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         ph_stall = 0;
         po_stall = 0;
      end else begin
         if (err_short) obs_err++;
         if (ph_stall) check_eq("hdr_hold", {valid_hdr, keep_hdr, data_hdr}, {1'b1, ph_k, ph_d});
         if (po_stall) check_eq("out_hold", {valid_out, last_out, keep_out, data_out}, {1'b1, po_l, po_k, po_d});
         if (valid_hdr && ready_hdr && !discard) begin
            if (eh_d.size() == 0) check_eq("hdr_extra", valid_hdr, 0);
            else begin
               check_eq("hdr_data", data_hdr, eh_d.pop_front());
               check_eq("hdr_keep", keep_hdr, eh_k.pop_front());
            end
         end
         if (valid_out && ready_out && !discard) begin
            if (eo_d.size() == 0) check_eq("out_extra", valid_out, 0);
            else begin
               check_eq("out_data", data_out, eo_d.pop_front());
               check_eq("out_keep", keep_out, eo_k.pop_front());
               check_eq("out_last", last_out, eo_l.pop_front());
            end
         end
         ph_stall = valid_hdr && !ready_hdr;
         ph_d = data_hdr;
         ph_k = keep_hdr;
         po_stall = valid_out && !ready_out;
         po_d = data_out;
         po_k = keep_out;
         po_l = last_out;
      end
   end

   initial begin
      int B, k;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready_strip", ready_strip, 0);
      check_eq("rst_ready_in", ready_in, 0);
      check_eq("rst_valids", {valid_hdr, valid_out, err_short, last_out}, 0);
      check_eq("rst_hdr", {data_hdr, keep_hdr}, 0);
      check_eq("rst_out", {data_out, keep_out}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_strip_after_rst", ready_strip, 1);
      @(posedge clk);
      #1;

      set_pkt(64'hA1A2A3A4B1B2, 6);            send_pkt(3'd2);
      set_pkt(64'h11223344556677, 7);          send_pkt(3'd1);
      set_pkt(64'hCAFEBABE12, 5);              send_pkt(3'd0);
      set_pkt(64'hDEADBEEF01020304, 8);        send_pkt(3'd4);
      set_pkt(64'h010203040506, 6);            send_pkt(3'd7);

      set_pkt(64'hCAFE, 2);
      send_pkt(3'd3);
      @(negedge clk);
      check_eq("short_err_pulse", err_short, 1);
      check_eq("short_ready_strip", ready_strip, 1);
      check_eq("short_no_out", valid_out, 0);
      @(negedge clk);
      check_eq("short_err_drop", err_short, 0);
      @(posedge clk);
      #1;

      // Header stall: a pending header must block the next packet's first beat.
      drain();
      hold_hdr = 1;
      @(posedge clk);
      #3;
      set_pkt(64'h10203040, 4);
      send_pkt(3'd2);
      set_pkt(64'h5060708090, 5);
      model_pkt(1);
      send_strip(3'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("stall_ready_in", ready_in, 0);
      end
      hold_hdr = 0;
      @(posedge clk);
      #1;
      send_beats();

      for (int p = 0; p < 100; p++) begin
         B = $urandom_range(1, 20);
         k = $urandom_range(1, NB);
         pkt.delete();
         for (int i = 0; i < (B - 1) * NB + k; i++) pkt.push_back(8'($urandom));
         send_pkt(3'($urandom_range(0, 4)));
      end

      // Reset in the middle of a packet body.
      drain();
      discard = 1;
      send_strip(3'd1);
      send_beat($urandom, 4'hF, 1'b0);
      send_beat($urandom, 4'hF, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("midrst_valids", {valid_hdr, valid_out}, 0);
      check_eq("midrst_ready_in", ready_in, 0);
      check_eq("midrst_ready_strip", ready_strip, 1);
      discard = 0;
      @(posedge clk);
      #1;
      set_pkt(64'h0A0B0C0D0E0F, 6);
      send_pkt(3'd3);

      drain();
      check_eq("hdr_left", eh_d.size(), 0);
      check_eq("out_left", eo_d.size(), 0);
      check_eq("err_count", obs_err, exp_err);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Receive-side counterpart of the header inserter: accepts an AXI-Stream packet whose first `byte_strip_cnt` bytes are a header, emits those bytes on a header channel, and emits the remaining payload re-aligned to the MSB byte lane. It sits at the ingress of the packet path, ahead of payload consumers. Byte 0 of a beat is `data[DATA_WD-1 -: 8]`, and `keep[DATA_BYTE_WD-1]` qualifies byte 0.

## Interface

Parameters:
- `DATA_WD`, 32, data width in bits.
- `DATA_BYTE_WD`, `DATA_WD/8`, byte lanes.
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, byte-count width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `valid_strip` input 1: strip-count channel valid.
- `byte_strip_cnt` input `BYTE_CNT_WD+1`: number of header bytes to strip, 0..`DATA_BYTE_WD`. Larger values are clamped to `DATA_BYTE_WD`.
- `ready_strip` output 1: strip-count channel ready.
- `valid_in`, `data_in[DATA_WD]`, `keep_in[DATA_BYTE_WD]`, `last_in`: input stream from upstream.
- `ready_in` output 1: input stream ready.
- `valid_hdr`, `data_hdr[DATA_WD]`, `keep_hdr[DATA_BYTE_WD]`: header output. Header bytes are right-aligned and `keep_hdr` is a low-contiguous mask.
- `ready_hdr` input 1: header output ready.
- `valid_out`, `data_out[DATA_WD]`, `keep_out[DATA_BYTE_WD]`, `last_out`: payload output. `keep_out` is left-aligned.
- `ready_out` input 1: payload output ready.
- `err_short` output 1: one-cycle pulse when a packet is shorter than its header.

## Operation

**Input rules**
- Non-last input beats carry `keep_in` all ones.
- The last beat carries a left-aligned contiguous keep with k ones, 1..`DATA_BYTE_WD`.

**State machine: IDLE, HEAD, BODY, FLUSH.**
- **IDLE**
  - `ready_strip`=1 and `ready_in`=0.
  - On `valid_strip`&&`ready_strip`, latch c=min(`byte_strip_cnt`,`DATA_BYTE_WD`) and set r=`DATA_BYTE_WD`-c, then go to HEAD.
- **HEAD** (first beat)
  - `ready_in` = (`!valid_hdr`||`ready_hdr`) && (`!valid_out`||`ready_out`).
  - On accept with c>0: load the header with the top c bytes of `data_in`, right-aligned, and `keep_hdr`=(1<<c)-1.
  - On accept, store the lower r bytes of `data_in` as the residual.
  - If not last: go to BODY.
  - If last and k>c: load one payload beat containing the k-c bytes following the header, with `last_out`=1, then go to IDLE.
  - If last and k==c: header only, no payload beat, go to IDLE.
  - If last and k<c: the header takes the k bytes present, right-aligned, with `keep_hdr`=(1<<k)-1. Pulse `err_short`, emit no payload, go to IDLE.
- **BODY**
  - `ready_in` = `!valid_out`||`ready_out`.
  - Each accepted beat loads the payload beat = top `DATA_BYTE_WD` bytes of {residual (r bytes), `data_in`}. The new residual is the lower r bytes of `data_in`.
  - On the last beat with r+k ≤ `DATA_BYTE_WD`: the payload beat has `keep_out` = top (r+k) ones and `last_out`=1, then go to IDLE.
  - On the last beat with r+k > `DATA_BYTE_WD`: the beat is full with `last_out`=0, then go to FLUSH.
- **FLUSH**
  - `ready_in`=0.
  - When the output slot is free, load the residual beat with `keep_out` = top (r+k-`DATA_BYTE_WD`) ones and `last_out`=1, then go to IDLE.

**Boundary values of c**
- c=0: no header beat; the payload lags the input by one beat, and a flush beat always follows.
- c=`DATA_BYTE_WD`: the whole first beat is header; payload beats equal the input beats.

**Output register rules**
- Header and payload outputs are registers and hold stable while valid && !ready.
- Valid deasserts on a handshake unless a new beat is loaded in the same cycle.

## Timing

**Reset values**
- `valid_hdr`=0, `valid_out`=0, `data_hdr`=0, `keep_hdr`=0, `data_out`=0, `keep_out`=0, `last_out`=0, `err_short`=0.
- State=IDLE, so `ready_in`=0.
- `ready_strip` is 0 while `rst_n`=0 and 1 in the first cycle after release.
- Reset mid-packet discards all state and registered beats.

**Latency**
- Strip-count handshake to earliest `ready_in`=1: 1 cycle.
- Input handshake to `valid_hdr`/`valid_out` asserted: 1 cycle.

**Throughput and flow control**
- Throughput is 1 beat/cycle in BODY with `ready_out` held high.
- A FLUSH costs one extra output cycle.
- `ready_in`, `ready_strip` and `err_short` are registered-state-derived, with no combinational path from `valid_in`.
- `ready_out`/`ready_hdr` may feed `ready_in` combinationally.

## Test plan

- **c=2:** beats 0xA1A2A3A4/1111, then 0xB1B2B3B4/1100 last → hdr 0x0000A1A2/0011; out 0xA3A4B1B2/1111 `last_out`=1; no flush.
- **c=1:** beats 0x11223344/1111, then 0x55667788/1110 last → hdr 0x00000011/0001; out 0x22334455/1111 `last_out`=0, then 0x66770000/1100 `last_out`=1.
- **c=0 and c=4:**
  - c=0 with 0xCAFEBABE, then 0x12000000/1000 last → no `valid_hdr`; out 0xCAFEBABE/1111, then 0x12000000/1000 `last_out`=1.
  - c=4 with 0xDEADBEEF, then 0x01020304 last → hdr 0xDEADBEEF/1111; out 0x01020304/1111 `last_out`=1.
- **Short packet:** c=3, single beat 0xCAFE0000/1100 last → hdr 0x0000CAFE/0011; `err_short` high exactly 1 cycle; no `valid_out`; `ready_strip`=1 next cycle.
- **Backpressure:**
  - Random `ready_out` and random `valid_in` gaps, plus `ready_hdr` held low 5 cycles during HEAD → `ready_in`=0 throughout the stall.
  - Outputs stay stable while stalled; the byte stream matches the scoreboard across 100 random packets with c∈0..4 and lengths 1..20 beats.
- **Reset mid-BODY:** `rst_n`=0 for 1 cycle → all valids 0 next cycle, state IDLE; the next packet is processed correctly.
